// File: rtl/edge_toggle_tx.sv
// Toggle-line event transmitter: each queued event becomes one level change on sig,
// with a minimum hold between changes so a once-per-clock edge detector never misses one.
module edge_toggle_tx #(
    parameter int   HOLD       = 2,
    parameter int   CNT_W      = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev,
    input  logic             clr_ovf,
    output logic             sig,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    localparam logic [7:0]       HOLD_RELOAD = 8'(HOLD - 1);
    localparam logic [CNT_W-1:0] PEND_MAX    = '1;
    localparam logic [CNT_W-1:0] PEND_ONE    = CNT_W'(1);

    state_t     state;
    logic [7:0] timer;
    logic       emit;
    logic       drop;

    // A same-cycle request is served straight from the input, so an idle
    // line answers ev without first parking it in the counter.
    assign emit = (state == S_IDLE) && ((pending != '0) || ev);
    assign drop = ev && !emit && (pending == PEND_MAX);
    assign busy = (state == S_HOLD) || (pending != '0);

    // NOTE: every register below is assigned with <= so all updates see the
    // pre-edge values of emit/drop, exactly as the combinational terms above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig     <= INIT_LEVEL;
            state   <= S_IDLE;
            timer   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            if (emit) begin
                sig <= ~sig;
            end

            case (state)
                S_IDLE: begin
                    if (emit && (HOLD > 1)) begin
                        state <= S_HOLD;
                        timer <= HOLD_RELOAD;
                    end
                end
                S_HOLD: begin
                    timer <= timer - 8'd1;
                    if (timer == 8'd1) begin
                        state <= S_IDLE;
                    end
                end
            endcase

            // inc and dec together cancel; a full counter drops the new event.
            if (ev && !emit && (pending != PEND_MAX)) begin
                pending <= pending + PEND_ONE;
            end else if (!ev && emit) begin
                pending <= pending - PEND_ONE;
            end

            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
